dram_ctrl: RTL
==============

DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 Parameter: DEPTH, default 4, request-queue entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents a command.
REQ-005 req_ready  output  1  queue can accept a command.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  4  target word address.
REQ-008 req_wdata  input  8  write data; ignored for reads.
REQ-009 rsp_valid  output  1  one-cycle read-data strobe.
REQ-010 rsp_data  output  8  read data, valid while rsp_valid=1.
REQ-011 dram_state  input  2  memory FSM state: 00 IDLE, 01 READ, 10 WRITE, 11 REFRESH.
REQ-012 dram_read_r  output  1  read command to memory.
REQ-013 dram_write_r  output  1  write command to memory.
REQ-014 dram_addr  output  4  command address.
REQ-015 dram_data  output  8  command write data.
REQ-016 dram_read_data  input  8  memory read port, updated on the edge that issues a read.

Function
REQ-017 Handshake: a command is accepted on an edge with req_valid=1 and req_ready=1; req_ready = !full, with no dependence on req_valid.
REQ-018 Queue: in-order FIFO of {we, addr, wdata}, DEPTH entries, wrap-around pointers, occupancy counter 0..DEPTH.
REQ-019 Full: accept blocked even if a pop occurs in the same cycle; empty: no issue.
REQ-020 Simultaneous push and pop (not full): both take effect; occupancy unchanged.
REQ-021 FSM states: S_IDLE, S_BUSY.
REQ-022 Issue condition: S_IDLE, queue non-empty, dram_state==IDLE.
REQ-023 While the issue condition holds, dram_read_r or dram_write_r (per head.we, exactly one) is driven combinationally high, with dram_addr/dram_data = head fields; otherwise both commands are 0.
REQ-024 At the issue edge: pop head; go to S_BUSY; record whether the command is a read.
REQ-025 S_BUSY lasts exactly one cycle and then returns to S_IDLE unconditionally; no command is driven in S_BUSY.
REQ-026 Read return: on the edge leaving S_BUSY after a read, rsp_data <= dram_read_data and rsp_valid <= 1; rsp_valid drops the following cycle.
REQ-027 Latency: read command high in cycle N gives rsp_valid high in cycle N+2; the minimum issue-to-issue spacing is 2 cycles.
REQ-028 A command accepted in cycle N is issuable no earlier than cycle N+1 (no bypass).
REQ-029 dram_state REFRESH/READ/WRITE in S_IDLE: hold the command, keep the queue intact, drive no command.
REQ-030 rsp_valid is never asserted for writes; there is no response back-pressure.
REQ-031 Ordering: commands issue strictly in acceptance order (read-after-write to the same address returns the new data).
REQ-032 When inactive, dram_addr and dram_data are 0.

Reset
REQ-033 Reset: S_IDLE, queue empty (pointers and count 0), rsp_valid=0, rsp_data=0, req_ready=1, command outputs 0.
REQ-034 Reset mid-operation discards queued commands and any in-flight read response; no rsp_valid follows.

Structure
REQ-035 Shared package dram_pkg: dram_state encodings (IDLE/READ/WRITE/REFRESH), ADDR_W=4, DATA_W=8, controller state encodings.
REQ-036 One sub-module: req_fifo (parameterised sync FIFO, async active-high reset), instantiated once.

Verification
REQ-037 Write 0x5A to addr 3, then read addr 3, dram_state tied to the memory model -> rsp_valid one cycle, rsp_data=0x5A, 2 cycles after dram_read_r.
REQ-038 Push 4 commands with no issue (dram_state held 11) -> req_ready=0 after the 4th accept; a 5th req_valid is not accepted; queue contents are intact when released.
REQ-039 Full queue, dram_state=00 with req_valid held -> pop and accept both occur only after the pop cycle; order is preserved.
REQ-040 Reads to addrs 0,1,2 after writes 0x11,0x22,0x33 -> responses 0x11,0x22,0x33 in order, each 2 cycles after its issue.
REQ-041 Assert reset during S_BUSY of a read -> no rsp_valid, req_ready=1, commands 0 next cycle.
REQ-042 Write-only stream -> rsp_valid stays 0 throughout.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command controller: bus widths, memory-side
// state encodings, controller FSM states and the queued command payload.
package dram_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W;

   // State reported by the memory device
   typedef enum logic [1:0] {
      DS_IDLE    = 2'b00,
      DS_READ    = 2'b01,
      DS_WRITE   = 2'b10,
      DS_REFRESH = 2'b11
   } dram_state_e;

   // Controller FSM
   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } ctrl_state_e;

   // One queued request
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } dram_cmd_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous in-order FIFO with wrap-around pointers and an occupancy counter.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_push, i_wdata     write request; ignored while full (even if popping)
//   i_pop               remove head; ignored while empty
//   o_rdata             current head entry (combinational read)
//   o_full, o_empty     occupancy flags
module req_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 13
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_rdata = r_mem[r_rd_ptr];

   // Storage array; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dram_ctrl.sv
// DRAM command controller: queues requester commands and issues them in order
// to the memory whenever it reports IDLE, returning read data two cycles after
// a read command.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_we, req_addr, req_wdata       request payload
//   rsp_valid, rsp_data               one-cycle read-data strobe and data
//   dram_state                        memory device state (00 = IDLE)
//   dram_read_r, dram_write_r         command strobes (combinational)
//   dram_addr, dram_data              command address / write data, 0 when idle
//   dram_read_data                    memory read port
module dram_ctrl
   import dram_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   input  logic [1:0]        dram_state,
   output logic              dram_read_r,
   output logic              dram_write_r,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [DATA_W-1:0] dram_data,
   input  logic [DATA_W-1:0] dram_read_data
);

   ctrl_state_e       r_state;
   ctrl_state_e       w_next_state;
   logic              r_is_read;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              w_issue;
   logic              w_full;
   logic              w_empty;
   dram_cmd_t         w_req_cmd;
   dram_cmd_t         w_head;
   logic [CMD_W-1:0]  w_head_bits;

   assign w_req_cmd = '{we: req_we, addr: req_addr, wdata: req_wdata};
   assign w_head    = dram_cmd_t'(w_head_bits);
   assign req_ready = !w_full;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

   req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_req_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (req_valid),
      .i_wdata (CMD_W'(w_req_cmd)),
      .i_pop   (w_issue),
      .o_rdata (w_head_bits),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next state and command drive; a command is only presented while issuing
   always_comb begin
      w_next_state = r_state;
      w_issue      = 1'b0;
      dram_read_r  = 1'b0;
      dram_write_r = 1'b0;
      dram_addr    = '0;
      dram_data    = '0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && (dram_state_e'(dram_state) == DS_IDLE)) begin
               w_issue      = 1'b1;
               w_next_state = S_BUSY;
               dram_read_r  = !w_head.we;
               dram_write_r = w_head.we;
               dram_addr    = w_head.addr;
               dram_data    = w_head.wdata;
            end
         end
         S_BUSY:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Read response: memory data is captured on the edge that leaves S_BUSY
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_is_read   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         if (w_issue) r_is_read <= !w_head.we;
         r_rsp_valid <= (r_state == S_BUSY) && r_is_read;
         if ((r_state == S_BUSY) && r_is_read) r_rsp_data <= dram_read_data;
      end
   end

endmodule
